// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter.
// Shares one datapath bus among NumberOfRequesters sources. It drives a
// registered binary Select for the shared bus mux and a registered one-hot
// Grant back to each requester. Every change of owner passes through one dead
// TURNAROUND cycle. An optional hold limit forcibly ends long grants.
// NumberOfRequesters must be at least 2.
module bus_arbiter_rr #(
  parameter int NumberOfRequesters = 4,
  parameter int MaxHoldCycles      = 8
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NumberOfRequesters-1:0] Request,
  output logic [NumberOfRequesters-1:0] Grant,
  output logic [NumberOfRequesters-1:0] Select,
  output logic                          BusValid,
  output logic                          HoldExpired
);

  localparam int N  = NumberOfRequesters;
  // Width of a requester index.
  localparam int PW = (N < 2) ? 1 : $clog2(N);
  // Width of the hold counter. It is large enough to hold MaxHoldCycles.
  localparam int HW = (MaxHoldCycles < 2) ? 1 : $clog2(MaxHoldCycles + 1);

  // The count value at which the owner has held the bus MaxHoldCycles cycles.
  // The counter is 0 in the first grant cycle.
  localparam int              HOLD_LAST_INT = (MaxHoldCycles == 0) ? 0 : MaxHoldCycles - 1;
  localparam logic [HW-1:0]   HOLD_LAST     = HOLD_LAST_INT[HW-1:0];
  localparam logic [PW-1:0]   LAST_IDX      = PW'(N - 1);
  localparam logic            HOLD_LIMITED  = (MaxHoldCycles != 0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   pointer;
  logic [PW-1:0]   owner;
  logic [HW-1:0]   hold_count;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic            owner_req;
  logic            hold_limit_hit;
  logic [PW-1:0]   next_pointer;
  logic [N-1:0]    win_onehot;
  logic [N-1:0]    win_select;

  // Returns the first requesting index. The search starts at ptr and wraps
  // modulo N. The result is {found, index}.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] req,
                                          input logic [PW-1:0] ptr);
    logic          found;
    logic [PW-1:0] idx;
    logic [PW-1:0] cand;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
      cand = (cand == LAST_IDX) ? {PW{1'b0}} : cand + PW'(1);
    end
    return {found, idx};
  endfunction

  // Expands an index into a one-hot Grant vector.
  function automatic logic [N-1:0] to_onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign {win_found, win_idx} = rr_pick(Request, pointer);
  assign win_onehot           = to_onehot(win_idx);
  assign win_select           = {{(N - PW){1'b0}}, win_idx};
  assign owner_req            = Request[owner];
  assign hold_limit_hit       = HOLD_LIMITED && (hold_count == HOLD_LAST);
  // After a release, the pointer moves just past the leaving owner.
  // This gives that owner the lowest priority in the next round.
  assign next_pointer         = (owner == LAST_IDX) ? {PW{1'b0}} : owner + PW'(1);

  // Arbitration FSM with registered Grant, Select, BusValid and HoldExpired.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pointer     <= {PW{1'b0}};
      owner       <= {PW{1'b0}};
      hold_count  <= {HW{1'b0}};
      Grant       <= {N{1'b0}};
      Select      <= {N{1'b0}};
      BusValid    <= 1'b0;
      HoldExpired <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          HoldExpired <= 1'b0;
          if (win_found) begin
            owner      <= win_idx;
            Grant      <= win_onehot;
            Select     <= win_select;
            BusValid   <= 1'b1;
            hold_count <= {HW{1'b0}};
            state      <= BUSY;
          end else begin
            // Select keeps the last owner so the mux output does not glitch.
            state <= IDLE;
          end
        end

        BUSY: begin
          if (!owner_req) begin
            // The owner has finished. Select keeps pointing at it.
            Grant       <= {N{1'b0}};
            BusValid    <= 1'b0;
            HoldExpired <= 1'b0;
            pointer     <= next_pointer;
            state       <= TURNAROUND;
          end else if (hold_limit_hit) begin
            // The owner still wants the bus but has used its full budget.
            Grant       <= {N{1'b0}};
            BusValid    <= 1'b0;
            HoldExpired <= 1'b1;
            pointer     <= next_pointer;
            state       <= TURNAROUND;
          end else begin
            hold_count  <= hold_count + HW'(1);
            HoldExpired <= 1'b0;
          end
        end

        TURNAROUND: begin
          // This is the single dead bus cycle. The next owner is chosen at its exit.
          HoldExpired <= 1'b0;
          if (win_found) begin
            owner      <= win_idx;
            Grant      <= win_onehot;
            Select     <= win_select;
            BusValid   <= 1'b1;
            hold_count <= {HW{1'b0}};
            state      <= BUSY;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          Grant       <= {N{1'b0}};
          BusValid    <= 1'b0;
          HoldExpired <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (N=4, MaxHoldCycles=4).
// It runs directed scenarios followed by randomized requests. Every step is
// compared against a behavioural model of the ownership rules.
module tb_bus_arbiter_rr;

  localparam int N   = 4;
  localparam int MAX = 4;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [N-1:0] Request;
  logic [N-1:0] Grant;
  logic [N-1:0] Select;
  logic         BusValid;
  logic         HoldExpired;

  int checks = 0;
  int errors = 0;

  // Behavioural model: current owner (-1 = none), rotating start point,
  // last selected index, cycles owned so far, and expiry flag.
  int   m_owner;
  int   m_ptr;
  int   m_sel;
  int   m_owned;
  logic m_expired;

  int           order[$];
  logic [N-1:0] prev_grant;

  bus_arbiter_rr #(
    .NumberOfRequesters(N),
    .MaxHoldCycles     (MAX)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Request    (Request),
    .Grant      (Grant),
    .Select     (Select),
    .BusValid   (BusValid),
    .HoldExpired(HoldExpired)
  );

  always #5 Clock = ~Clock;

  function automatic logic bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = 0;
    m_sel      = 0;
    m_owned    = 0;
    m_expired  = 1'b0;
    prev_grant = '0;
  endtask

  // The owner keeps the bus while it requests and is under budget.
  // Otherwise the bus goes dead for a cycle. A free bus goes to the first
  // requester found from the rotating start point.
  task automatic model_edge(input logic [N-1:0] r);
    if (m_owner >= 0) begin
      if (!bit_at(r, m_owner) || (MAX != 0 && m_owned == MAX)) begin
        m_expired = bit_at(r, m_owner);
        m_ptr     = (m_owner + 1) % N;
        m_owner   = -1;
      end else begin
        m_owned++;
      end
    end else begin
      m_expired = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bit_at(r, (m_ptr + k) % N)) begin
          m_owner = (m_ptr + k) % N;
          m_sel   = m_owner;
          m_owned = 1;
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] eg;
    int           gi;
    eg = '0;
    if (m_owner >= 0) eg = N'(1) << m_owner;
    check("grant",        32'(Grant),       32'(eg));
    check("select",       32'(Select),      32'(m_sel));
    check("bus_valid",    32'(BusValid),    32'(m_owner >= 0));
    check("hold_expired", 32'(HoldExpired), 32'(m_expired));
    if (Grant != '0 && Grant != prev_grant) begin
      gi = 0;
      for (int k = 0; k < N; k++) if (bit_at(Grant, k)) gi = k;
      order.push_back(gi);
    end
    prev_grant = Grant;
  endtask

  // Drive on the falling edge, let the model see the same request at the
  // rising edge, then sample just after it.
  task automatic step(input logic [N-1:0] r);
    @(negedge Clock);
    Request = r;
    @(posedge Clock);
    model_edge(r);
    #1;
    compare_model();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2;
    Reset   = 1'b1;
    Request = '0;
    #1;
    check("rst_grant",        32'(Grant),       32'h0);
    check("rst_select",       32'(Select),      32'h0);
    check("rst_bus_valid",    32'(BusValid),    32'h0);
    check("rst_hold_expired", 32'(HoldExpired), 32'h0);
    #2;
    Reset = 1'b0;
    model_reset();
    order.delete();
  endtask

  initial begin
    int           run;
    int           ghigh;
    int           nexp;
    logic [N-1:0] last_g;
    logic [N-1:0] r;
    int           exp_rr[5];
    int           exp_fair[4];

    exp_rr   = '{0, 1, 2, 3, 0};
    exp_fair = '{0, 1, 0, 1};

    Reset   = 1'b1;
    Request = '0;
    model_reset();
    @(posedge Clock);
    #1;
    pulse_reset();

    // Reset in the middle of a grant.
    step(4'b0010);
    check("busy_before_reset", 32'(Grant), 32'h2);
    pulse_reset();
    step(4'b0100);
    check("grant_after_reset", 32'(Grant), 32'h4);

    // Single request, release, turnaround, then idle with Select held.
    pulse_reset();
    step(4'b0100);
    check("single_select", 32'(Select), 32'h2);
    step(4'b0000);
    check("single_release", 32'(Grant), 32'h0);
    step(4'b0000);
    step(4'b0000);
    check("idle_select_held", 32'(Select), 32'h2);

    // All four requesting, each owner drops after two cycles.
    pulse_reset();
    run    = 0;
    last_g = '0;
    for (int c = 0; c < 15; c++) begin
      r = 4'hF;
      if (run == 2) r = 4'hF & ~Grant;
      step(r);
      if (Grant == '0)         run = 0;
      else if (Grant == last_g) run++;
      else                      run = 1;
      last_g = Grant;
    end
    check("rr_order_len", 32'(order.size() >= 5), 32'h1);
    for (int j = 0; j < 5; j++) check("rr_order", 32'(order[j]), 32'(exp_rr[j]));

    // Sole requester held past the hold limit.
    pulse_reset();
    ghigh = 0;
    nexp  = 0;
    for (int c = 0; c < 10; c++) begin
      step(4'b0001);
      if (Grant != '0) ghigh++;
      if (HoldExpired) nexp++;
    end
    check("hold_grant_cycles", 32'(ghigh), 32'd8);
    check("hold_expired_pulses", 32'(nexp), 32'd2);

    // Two requesters held: expiry forces alternation.
    pulse_reset();
    for (int c = 0; c < 20; c++) step(4'b0011);
    check("fair_order_len", 32'(order.size() >= 4), 32'h1);
    for (int j = 0; j < 4; j++) check("fair_order", 32'(order[j]), 32'(exp_fair[j]));

    // Pointer wraps past 3 to 0.
    pulse_reset();
    step(4'b0100);
    step(4'b0000);
    step(4'b0011);
    check("wrap_grant", 32'(Grant), 32'h1);
    check("wrap_select", 32'(Select), 32'h0);

    // Randomized requests with occasional asynchronous resets.
    pulse_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      if ($urandom_range(0, 63) == 0) pulse_reset();
      step(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter that shares one datapath bus among NumberOfRequesters sources.
- Produces a registered binary Select that drives the team's Muxn (NumberOfInputs = NumberOfRequesters), plus a one-hot Grant back to each requester.
- Sits between the control unit's bus requesters (register file, ALU result, memory read, immediate) and the shared bus mux.
- Enforces a one-cycle turnaround between owners and an optional per-grant hold limit.

Parameters:
- NumberOfRequesters, 4, number of requesters and Muxn inputs; minimum 2.
- MaxHoldCycles, 8, maximum consecutive cycles one owner keeps the bus; 0 = unlimited. The hold-count width is sized to hold MaxHoldCycles.

Ports:
- Clock  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Request  input  NumberOfRequesters  bit i high = requester i wants the bus; held high until finished.
- Grant  output  NumberOfRequesters  one-hot, registered; bit i high = requester i owns the bus.
- Select  output  NumberOfRequesters  binary index of the current or last owner, registered; feeds Muxn Select.
- BusValid  output  1  high while any Grant bit is high; qualifies the Muxn output.
- HoldExpired  output  1  one-cycle pulse when a grant is forcibly ended by the hold limit.

Behaviour:
- Reset (asynchronous, any time, including mid-grant):
  - State = IDLE; Grant = 0; Select = 0; BusValid = 0; HoldExpired = 0.
  - Pointer = 0; HoldCount = 0.
  - Request is ignored while Reset is high. The first arbitration is the first rising edge after Reset deasserts.
- States: IDLE, BUSY, TURNAROUND.
- Arbitration function, used in IDLE and at TURNAROUND exit:
  - Winner = first i with Request[i] = 1, searching Pointer, Pointer+1, ..., wrapping modulo NumberOfRequesters.
  - On a winner at the edge: Grant = one-hot(winner); Select = winner; BusValid = 1; HoldCount = 0; State = BUSY.
- IDLE:
  - Request == 0: stay in IDLE; Select holds its last value so the bus does not glitch.
  - Request != 0: arbitrate. Latency is exactly 1 edge: Request sampled at edge k gives Grant visible after edge k.
- BUSY (owner o):
  - Request bits other than o are ignored.
  - Each edge with Request[o] = 1 and the limit not reached: HoldCount += 1, outputs unchanged.
  - Release when Request[o] = 0 at an edge: Grant = 0; BusValid = 0; Pointer = (o+1) mod N; State = TURNAROUND. Select keeps o.
  - Forced release when MaxHoldCycles != 0 and HoldCount == MaxHoldCycles-1 at an edge with Request[o] still 1:
    - Same actions as a normal release, plus HoldExpired = 1 for exactly the following cycle.
    - Result: owner held Grant for exactly MaxHoldCycles cycles.
- TURNAROUND:
  - Lasts exactly one cycle with BusValid = 0 (bus dead cycle).
  - At its exit edge: arbitrate if Request != 0, else go to IDLE.
  - HoldExpired returns to 0.
- Fairness:
  - A requester that just released or expired has the lowest priority next round because Pointer has moved past it.
  - If it is the only requester still asserting, it is re-granted right after the turnaround.
- Pointer wraps from N-1 to 0.
- Invariants: Grant is always one-hot or zero; BusValid == |Grant; Select < NumberOfRequesters always.

Test Plan (N=4, MaxHoldCycles=4):
- Reset mid-BUSY: Reset asserted asynchronously between edges while Grant=0010 -> Grant=0000, Select=0, BusValid=0 immediately; after deassert, Request=0100 -> Grant=0100 at the next edge.
- Single request: Request=0100 from IDLE -> Grant=0100, Select=2, BusValid=1 after one edge; drop Request -> Grant=0000 after the next edge, then 1 TURNAROUND cycle, then IDLE with Select=2.
- Simultaneous requests: Request=1111 held, each owner drops after 2 cycles -> grant order 0,1,2,3,0; exactly one BusValid=0 cycle between owners.
- Hold limit: Request=0001 held 10 cycles -> Grant high 4 cycles, HoldExpired pulse, 1 dead cycle, re-grant 0 (sole requester); pattern repeats.
- Expiry fairness: Request=0011 held -> grants alternate 0,1,0,1, each 4 cycles long, with a HoldExpired pulse after each.
- Wrap-around: Pointer=3 after owner 2 releases, Request=0011 -> winner 0, not 1; Select=0.
